kart_compositor: RTL and testbench

- Parametrised per-pixel compositor for the kart renderer; generalises the fixed player/opponent track view to NUM_KARTS karts.
- Adds a scrolling camera and frame-synchronous (double-buffered) kart state.
- Fetches track pixels from an external fixed-latency track ROM, overlays priority-ordered kart sprites, and reports per-frame kart-kart collisions.
- Sits between the video timing generator and the output pixel mux.

---
 rtl/kart_compositor.sv | 205 ++++++++++++++++++++
 tb/tb_kart_compositor.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kart_compositor.sv
// kart_compositor
//   Per-pixel compositor for the kart renderer. Maps screen coordinates to
//   world coordinates through a scrolling camera, fetches the track pixel
//   from an external fixed-latency ROM, overlays up to NUM_KARTS priority
//   ordered kart sprites (lowest index on top) and reports per-frame
//   kart-kart collisions. Kart and camera state is double buffered: the
//   *_in shadow values are copied into the active set once per frame at
//   hcount_in==0, vcount_in==V_ACTIVE.
//
// Ports
//   clk_in, rst_n_in                 pixel clock, async active-low reset
//   hcount_in, vcount_in             raster position from the timing generator
//   cam_x_in, cam_y_in               camera world origin (shadow)
//   kart_x_in, kart_y_in             packed kart top-left coords (shadow)
//   kart_valid_in, kart_color_in     kart enables and RGB444 colours (shadow)
//   track_addr_x_out/_y_out          world address to the track ROM
//   track_pixel_in                   ROM data, TRACK_LATENCY cycles later
//   pixel_out, hcount_out, vcount_out composited pixel and aligned raster pos
//   collision_out                    per-kart collision flags, previous frame
//   frame_done_out                   one-cycle pulse after the frame latch
//
// Build option
//   KART_OUTLINE_EN  when defined, the non-corner border ring of every sprite
//                    is drawn black instead of the kart colour.

module kart_compositor #(
  parameter int NUM_KARTS     = 4,
  parameter int COORD_W       = 11,
  parameter int SPRITE_SIZE   = 16,
  parameter int PIXEL_W       = 12,
  parameter int H_ACTIVE      = 1024,
  parameter int V_ACTIVE      = 768,
  parameter int TRACK_LATENCY = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic [COORD_W-1:0]           cam_x_in,
  input  logic [COORD_W-1:0]           cam_y_in,
  input  logic [NUM_KARTS*COORD_W-1:0] kart_x_in,
  input  logic [NUM_KARTS*COORD_W-1:0] kart_y_in,
  input  logic [NUM_KARTS-1:0]         kart_valid_in,
  input  logic [NUM_KARTS*PIXEL_W-1:0] kart_color_in,
  output logic [COORD_W-1:0]           track_addr_x_out,
  output logic [COORD_W-1:0]           track_addr_y_out,
  input  logic [PIXEL_W-1:0]           track_pixel_in,
  output logic [PIXEL_W-1:0]           pixel_out,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out,
  output logic [NUM_KARTS-1:0]         collision_out,
  output logic                         frame_done_out
);

  localparam int LAT   = TRACK_LATENCY;
  localparam int DEPTH = TRACK_LATENCY + 2;
  localparam logic [COORD_W-1:0] SPR_N = COORD_W'(SPRITE_SIZE);
  localparam logic [COORD_W-1:0] SPR_L = COORD_W'(SPRITE_SIZE - 1);

  // active (frame-latched) state
  logic [COORD_W-1:0]           cam_x_q, cam_y_q;
  logic [NUM_KARTS*COORD_W-1:0] kx_q, ky_q;
  logic [NUM_KARTS-1:0]         valid_q;
  logic [NUM_KARTS*PIXEL_W-1:0] color_q;
  logic [NUM_KARTS-1:0]         coll_acc;

  logic                         latch;
  logic                         act_s0;
  logic [NUM_KARTS-1:0]         hit_s0;
  logic [NUM_KARTS-1:0]         hit_pipe [LAT];
  logic                         act_pipe [LAT];
  logic [10:0]                  hc_pipe  [DEPTH];
  logic [9:0]                   vc_pipe  [DEPTH];
  logic [NUM_KARTS-1:0]         hit_d;
  logic                         act_d;
  logic [PIXEL_W-1:0]           pix_sel;
  logic [3:0]                   n_hit;
  logic                         found;
`ifdef KART_OUTLINE_EN
  logic [NUM_KARTS-1:0]         edge_s0;
  logic [NUM_KARTS-1:0]         edge_pipe [LAT];
  logic [NUM_KARTS-1:0]         edge_d;
  assign edge_d = edge_pipe[LAT-1];
`endif

  assign latch      = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
  assign hit_d      = hit_pipe[LAT-1];
  assign act_d      = act_pipe[LAT-1];
  assign hcount_out = hc_pipe[DEPTH-1];
  assign vcount_out = vc_pipe[DEPTH-1];

  // Hit test against the registered world address (the S0 stage). Modular
  // subtraction makes sprites straddling the coordinate wrap draw naturally.
  always_comb begin
    logic [COORD_W-1:0] dx, dy;
    logic               in_box, corner;
    dx     = '0;
    dy     = '0;
    in_box = 1'b0;
    corner = 1'b0;
    hit_s0 = '0;
`ifdef KART_OUTLINE_EN
    edge_s0 = '0;
`endif
    for (int k = 0; k < NUM_KARTS; k++) begin
      dx        = track_addr_x_out - kx_q[k*COORD_W +: COORD_W];
      dy        = track_addr_y_out - ky_q[k*COORD_W +: COORD_W];
      in_box    = (dx < SPR_N) && (dy < SPR_N);
      corner    = ((dx == '0) || (dx == SPR_L)) && ((dy == '0) || (dy == SPR_L));
      hit_s0[k] = valid_q[k] && in_box && !corner;
`ifdef KART_OUTLINE_EN
      edge_s0[k] = (dx == '0) || (dx == SPR_L) || (dy == '0) || (dy == SPR_L);
`endif
    end
  end

  // Priority select: lowest-index hitting kart wins; also count hits.
  always_comb begin
    pix_sel = track_pixel_in;
    found   = 1'b0;
    n_hit   = '0;
    for (int k = 0; k < NUM_KARTS; k++) begin
      n_hit = n_hit + 4'(hit_d[k]);
      if (hit_d[k] && !found) begin
        found   = 1'b1;
        pix_sel = color_q[k*PIXEL_W +: PIXEL_W];
`ifdef KART_OUTLINE_EN
        if (edge_d[k]) pix_sel = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cam_x_q          <= '0;
      cam_y_q          <= '0;
      kx_q             <= '0;
      ky_q             <= '0;
      valid_q          <= '0;
      color_q          <= '0;
      coll_acc         <= '0;
      collision_out    <= '0;
      frame_done_out   <= 1'b0;
      track_addr_x_out <= '0;
      track_addr_y_out <= '0;
      act_s0           <= 1'b0;
      pixel_out        <= '0;
      for (int i = 0; i < LAT; i++) begin
        hit_pipe[i] <= '0;
        act_pipe[i] <= 1'b0;
`ifdef KART_OUTLINE_EN
        edge_pipe[i] <= '0;
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
        hc_pipe[i] <= '0;
        vc_pipe[i] <= '0;
      end
    end else begin
      // The clear wins over a same-cycle accumulation; in legal timing the
      // latch sits in blanking so nothing is lost.
      if (latch) begin
        cam_x_q       <= cam_x_in;
        cam_y_q       <= cam_y_in;
        kx_q          <= kart_x_in;
        ky_q          <= kart_y_in;
        valid_q       <= kart_valid_in;
        color_q       <= kart_color_in;
        collision_out <= coll_acc;
        coll_acc      <= '0;
      end else if (act_d && (n_hit >= 4'd2)) begin
        coll_acc <= coll_acc | hit_d;
      end
      frame_done_out <= latch;

      track_addr_x_out <= cam_x_q + COORD_W'(hcount_in);
      track_addr_y_out <= cam_y_q + COORD_W'(vcount_in);
      act_s0           <= (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));

      hit_pipe[0] <= hit_s0;
      act_pipe[0] <= act_s0;
`ifdef KART_OUTLINE_EN
      edge_pipe[0] <= edge_s0;
`endif
      for (int i = 1; i < LAT; i++) begin
        hit_pipe[i] <= hit_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
`ifdef KART_OUTLINE_EN
        edge_pipe[i] <= edge_pipe[i-1];
`endif
      end

      hc_pipe[0] <= hcount_in;
      vc_pipe[0] <= vcount_in;
      for (int i = 1; i < DEPTH; i++) begin
        hc_pipe[i] <= hc_pipe[i-1];
        vc_pipe[i] <= vc_pipe[i-1];
      end

      pixel_out <= act_d ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_kart_compositor.sv
// Testbench for kart_compositor. A bench-side model computes, for every
// presented raster position, the expected pixel / address / collision /
// frame pulse from world-coordinate arithmetic; a compare process checks the
// DUT against it every cycle, and literal expectations pin the model.
module tb_kart_compositor;
  localparam int NK   = 4;
  localparam int CW   = 11;
  localparam int SS   = 16;
  localparam int PW   = 12;
  localparam int HA   = 1024;
  localparam int VA   = 768;
  localparam int LAT  = 2;
  localparam int WMOD = 1 << CW;
  localparam int MAXE = 16384;

  logic              clk;
  logic              rst_n_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [CW-1:0]     cam_x_in, cam_y_in;
  logic [NK*CW-1:0]  kart_x_in, kart_y_in;
  logic [NK-1:0]     kart_valid_in;
  logic [NK*PW-1:0]  kart_color_in;
  logic [CW-1:0]     track_addr_x_out, track_addr_y_out;
  logic [PW-1:0]     track_pixel_in;
  logic [PW-1:0]     pixel_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;
  logic [NK-1:0]     collision_out;
  logic              frame_done_out;

  kart_compositor #(
    .NUM_KARTS(NK), .COORD_W(CW), .SPRITE_SIZE(SS), .PIXEL_W(PW),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .TRACK_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .cam_x_in(cam_x_in), .cam_y_in(cam_y_in),
    .kart_x_in(kart_x_in), .kart_y_in(kart_y_in),
    .kart_valid_in(kart_valid_in), .kart_color_in(kart_color_in),
    .track_addr_x_out(track_addr_x_out), .track_addr_y_out(track_addr_y_out),
    .track_pixel_in(track_pixel_in),
    .pixel_out(pixel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .collision_out(collision_out), .frame_done_out(frame_done_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // track ROM: fixed-latency lookup of a position-dependent pattern
  function automatic logic [PW-1:0] rom_f(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return 12'hABC + {y[5:0], x[5:0]};
  endfunction

  logic [CW-1:0] rq_x [LAT];
  logic [CW-1:0] rq_y [LAT];
  always @(posedge clk) begin
    rq_x[0] <= track_addr_x_out;
    rq_y[0] <= track_addr_y_out;
    for (int i = 1; i < LAT; i++) begin
      rq_x[i] <= rq_x[i-1];
      rq_y[i] <= rq_y[i-1];
    end
  end
  assign track_pixel_in = rom_f(rq_x[LAT-1], rq_y[LAT-1]);

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // expectations indexed by the clock edge that samples the input
  logic [PW-1:0] e_pix  [MAXE];
  logic [10:0]   e_h    [MAXE];
  logic [9:0]    e_v    [MAXE];
  logic [CW-1:0] e_ax   [MAXE];
  logic [CW-1:0] e_ay   [MAXE];
  logic [NK-1:0] e_coll [MAXE];
  logic          e_fd   [MAXE];

  int total = 0;
  int bad   = 0;
  int rst_edge = 0;
  bit run = 0;

  // model state
  int      m_cam_x, m_cam_y;
  int      m_kx [NK];
  int      m_ky [NK];
  bit      m_v  [NK];
  int      m_col[NK];
  bit [NK-1:0] m_acc, m_coll;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cam_x = 0; m_cam_y = 0; m_acc = '0; m_coll = '0;
    for (int k = 0; k < NK; k++) begin
      m_kx[k] = 0; m_ky[k] = 0; m_v[k] = 0; m_col[k] = 0;
    end
  endtask

  task automatic model_eval(input int h, input int v);
    int e, wx, wy, dx, dy, first;
    bit [NK-1:0] hits;
    bit on_edge;
    e = edge_cnt + 1;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: got=%0d want<%0d", e, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    wx = (m_cam_x + h) % WMOD;
    wy = (m_cam_y + v) % WMOD;
    e_ax[e] = CW'(wx);
    e_ay[e] = CW'(wy);
    e_fd[e] = (h == 0 && v == VA);
    if (h == 0 && v == VA) begin
      m_coll  = m_acc;
      m_acc   = '0;
      m_cam_x = int'(cam_x_in);
      m_cam_y = int'(cam_y_in);
      for (int k = 0; k < NK; k++) begin
        m_kx[k]  = int'(kart_x_in[k*CW +: CW]);
        m_ky[k]  = int'(kart_y_in[k*CW +: CW]);
        m_v[k]   = kart_valid_in[k];
        m_col[k] = int'(kart_color_in[k*PW +: PW]);
      end
    end
    e_coll[e] = m_coll;
    e_h[e]    = 11'(h);
    e_v[e]    = 10'(v);
    if (h >= HA || v >= VA) begin
      e_pix[e] = '0;
    end else begin
      hits = '0; first = -1; on_edge = 0;
      for (int k = 0; k < NK; k++) begin
        dx = (wx - m_kx[k] + WMOD) % WMOD;
        dy = (wy - m_ky[k] + WMOD) % WMOD;
        if (m_v[k] && dx < SS && dy < SS &&
            !((dx == 0 || dx == SS-1) && (dy == 0 || dy == SS-1))) begin
          hits[k] = 1'b1;
          if (first < 0) begin
            first   = k;
            on_edge = (dx == 0 || dx == SS-1 || dy == 0 || dy == SS-1);
          end
        end
      end
      if (first < 0) e_pix[e] = rom_f(CW'(wx), CW'(wy));
      else begin
        e_pix[e] = PW'(m_col[first]);
`ifdef KART_OUTLINE_EN
        if (on_edge) e_pix[e] = '0;
`endif
      end
      if ($countones(hits) >= 2) m_acc = m_acc | hits;
    end
  endtask

  // per-cycle compare against the model
  initial begin
    int n, j;
    logic [PW-1:0] ep;
    logic [10:0]   eh;
    logic [9:0]    ev;
    forever begin
      @(posedge clk);
      #1;
      if (run && rst_n_in) begin
        n = edge_cnt;
        j = n - (LAT + 1);
        if (j <= rst_edge) begin
          ep = '0; eh = '0; ev = '0;
        end else begin
          ep = e_pix[j]; eh = e_h[j]; ev = e_v[j];
        end
        chk("pixel", int'(pixel_out), int'(ep));
        chk("hcount_out", int'(hcount_out), int'(eh));
        chk("vcount_out", int'(vcount_out), int'(ev));
        chk("addr_x", int'(track_addr_x_out), int'(e_ax[n]));
        chk("addr_y", int'(track_addr_y_out), int'(e_ay[n]));
        chk("collision", int'(collision_out), int'(e_coll[n]));
        chk("frame_done", int'(frame_done_out), int'(e_fd[n]));
      end
    end
  end

  task automatic step(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    model_eval(h, v);
    @(negedge clk);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1100, 100);
  endtask

  task automatic do_latch();
    blank(LAT + 3);
    step(0, VA);
    blank(2);
  endtask

  task automatic probe(input int h, input int v, output int pix);
    step(h, v);
    blank(LAT + 1);
    pix = int'(pixel_out);
  endtask

  task automatic set_kart(input int k, input int x, input int y, input int c, input bit v);
    kart_x_in[k*CW +: CW]     = CW'(x);
    kart_y_in[k*CW +: CW]     = CW'(y);
    kart_color_in[k*PW +: PW] = PW'(c);
    kart_valid_in[k]          = v;
  endtask

  task automatic sweep(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) step(h, v);
  endtask

  initial begin
    int p;
    int exp_edge;
    rst_n_in = 1'b0;
    hcount_in = 11'd1100; vcount_in = 10'd100;
    cam_x_in = '0; cam_y_in = '0;
    kart_x_in = '0; kart_y_in = '0; kart_valid_in = '0; kart_color_in = '0;
    model_reset();
    repeat (3) @(negedge clk);

    chk("rst_pixel", int'(pixel_out), 0);
    chk("rst_hcount", int'(hcount_out), 0);
    chk("rst_vcount", int'(vcount_out), 0);
    chk("rst_addr", int'(track_addr_x_out), 0);
    chk("rst_collision", int'(collision_out), 0);
    chk("rst_frame_done", int'(frame_done_out), 0);

    rst_edge = edge_cnt;
    rst_n_in = 1'b1;
    run = 1;

    // shadow karts everywhere but no latch yet: track only
    set_kart(0, 64, 64, 12'hF00, 1);
    set_kart(1, 66, 66, 12'h0F0, 1);
    set_kart(2, 0, 0, 12'h00F, 1);
    set_kart(3, 70, 64, 12'hFF0, 1);
    sweep(0, 20, 0, 0);
    probe(0, 0, p);   chk("track_origin", p, 12'hABC);
    probe(70, 70, p); chk("track_no_latch", p, 12'hC42);

    // single kart
    set_kart(1, 0, 0, 0, 0); set_kart(2, 0, 0, 0, 0); set_kart(3, 0, 0, 0, 0);
    do_latch();
    sweep(60, 82, 64, 66);
    probe(70, 70, p); chk("kart0_body", p, 12'hF00);
    probe(64, 64, p); chk("kart0_corner", p, 12'hABC);
    probe(80, 70, p); chk("kart0_right_out", p, 12'hC4C);
`ifdef KART_OUTLINE_EN
    probe(64, 70, p); chk("kart0_outline", p, 12'h000);
`else
    probe(64, 70, p); chk("kart0_edge", p, 12'hF00);
`endif

    // overlapping karts: priority and collision
    set_kart(0, 100, 100, 12'hF00, 1);
    set_kart(1, 108, 108, 12'h0F0, 1);
    do_latch();
    probe(110, 110, p); chk("overlap_priority", p, 12'hF00);
    sweep(100, 120, 106, 112);
    set_kart(1, 300, 300, 12'h0F0, 1);
    do_latch();
    chk("collision_pair", int'(collision_out), 4'b0011);
    sweep(100, 120, 106, 112);
    sweep(295, 320, 305, 306);
    do_latch();
    chk("collision_apart", int'(collision_out), 0);

    // camera and kart straddling the coordinate wrap
    cam_x_in = CW'(2040); cam_y_in = '0;
    set_kart(0, 0, 0, 0, 0); set_kart(1, 0, 0, 0, 0);
    set_kart(2, 2044, 0, 12'h00F, 1);
    do_latch();
    sweep(0, 24, 4, 6);
    probe(3, 5, p);  chk("wrap_left_track", p, 12'hC37);
    probe(5, 5, p);  chk("wrap_kart_body", p, 12'h00F);
`ifdef KART_OUTLINE_EN
    probe(19, 5, p); chk("wrap_kart_last", p, 12'h000);
`else
    probe(19, 5, p); chk("wrap_kart_last", p, 12'h00F);
`endif
    probe(20, 5, p); chk("wrap_right_track", p, 12'hC08);
    step(10, 5);
    chk("addr_wrap", int'(track_addr_x_out), 2);
    blank(LAT + 1);

    // shadow change mid-frame is invisible until the latch
    set_kart(2, 100, 0, 12'h00F, 1);
    probe(5, 5, p);    chk("shadow_hold", p, 12'h00F);
    probe(1030, 5, p); chk("inactive_h", p, 0);
    do_latch();
    probe(5, 5, p);    chk("shadow_applied_track", p, 12'hC39);
    probe(110, 5, p);  chk("shadow_applied_kart", p, 12'h00F);

    // reset asserted right on the frame pulse
    cam_x_in = '0;
    set_kart(2, 0, 0, 0, 0);
    set_kart(0, 100, 100, 12'hF00, 1);
    set_kart(1, 108, 108, 12'h0F0, 1);
    do_latch();
    sweep(104, 116, 108, 110);
    blank(LAT + 3);
    hcount_in = 11'd0; vcount_in = 10'(VA);
    model_eval(0, VA);
    exp_edge = edge_cnt + 1;
    @(posedge clk);
    #2;
    chk("pulse_before_reset", int'(frame_done_out), 1);
    chk("coll_before_reset", int'(collision_out), 4'b0011);
    chk("hcount_before_reset", int'(hcount_out), 1100);
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_pulse", int'(frame_done_out), 0);
    chk("async_rst_coll", int'(collision_out), 0);
    chk("async_rst_hcount", int'(hcount_out), 0);
    chk("async_rst_pixel", int'(pixel_out), 0);
    hcount_in = 11'd1100; vcount_in = 10'd100;
    repeat (2) @(negedge clk);
    model_reset();
    rst_edge = edge_cnt;
    rst_n_in = 1'b1;
    probe(110, 110, p); chk("post_reset_track", p, 12'h66A);
    sweep(100, 112, 110, 110);
    blank(LAT + 4);

    run = 0;
    if (exp_edge <= 0) chk("edge_index", exp_edge, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
